mips32_issue_interlock: RTL
===========================

// Module: mips32_issue_interlock
// PURPOSE
//  Scoreboard issue controller for the 5-stage Pipelined_MIPS32 datapath; sits at the ID stage.
//  Detects RAW hazards and holds the decoded instruction in ID, inserting bubbles into ID/EX.
//  Removes the need for software-inserted dummy OR instructions.
//  Also squashes wrong-path issue on taken branches and sequences HLT drain to a clean halt.
// PARAMETERS
//  WB_DIST   3   min issue distance (cycles) producer->consumer, regfile write-before-read
//  LU_DIST   2   load->use issue distance, used only when MIPS32_FWD_EN is defined
//  CNT_W     2   scoreboard counter width; must hold max(WB_DIST,LU_DIST)-1
// PORTS
//  clk           in   1   single pipeline clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  id_valid      in   1   valid decoded instruction in IF/ID
//  id_rs         in   5   source register 1
//  id_rt         in   5   source register 2
//  id_uses_rs    in   1   instruction reads rs
//  id_uses_rt    in   1   instruction reads rt
//  id_wr_en      in   1   instruction writes a register
//  id_rd         in   5   destination register
//  id_is_load    in   1   instruction is LW
//  id_is_halt    in   1   instruction is HLT
//  branch_taken  in   1   taken branch resolved in EX/MEM; ID instruction is wrong-path
//  id_ready      out  1   issue this cycle (comb); id_valid&!id_ready = hold PC and IF/ID
//  bubble        out  1   load NOP into ID/EX this cycle (comb) = !(id_valid&id_ready)
//  pipe_halted   out  1   HLT fully drained, pipeline frozen
//  busy          out  1   any scoreboard counter nonzero or state DRAIN
//  stall_cnt     out  16  hazard-stall cycle counter, saturating
// BEHAVIOUR
//  - Reset (async): all 32 counters 0, state RUN, pipe_halted 0, stall_cnt 0, busy 0.
//  - Scoreboard cnt[0..31]; R0 is never tracked, reads of R0 never hazard.
//  - hazard = (id_uses_rs & cnt[id_rs]!=0) | (id_uses_rt & cnt[id_rt]!=0).
//  - id_ready = state==RUN & !hazard & !branch_taken. Issue = id_valid & id_ready.
//  - Each edge: every nonzero cnt decrements by 1.
//  - On issue with id_wr_en & id_rd!=0: cnt[id_rd] <= WB_DIST-1, overriding that entry's decrement.
//  - Result: dependent instruction issues exactly WB_DIST cycles after producer; WB_DIST-1 bubbles.
//  - branch_taken: no issue that cycle, bubble=1, no scoreboard write.
//    Entries already set by wrong-path instructions are not cleared. Cost is spurious stall only.
//  - stall_cnt increments when id_valid & hazard & state==RUN & !branch_taken; holds at 16'hFFFF.
//  - FSM:
//    RUN   -> DRAIN on issue of id_is_halt; drain timer <= WB_DIST-1.
//    DRAIN: id_ready=0. Timer decrements.
//      branch_taken -> RUN (halt was wrong-path), with priority.
//      Else timer==0 -> HALTED.
//      With WB_DIST-1==0, HALTED entered on the edge after issue.
//    HALTED: id_ready=0, bubble=1, pipe_halted=1; exits only via rst.
//  - Reset mid-stall or mid-drain: scoreboard and FSM cleared immediately; no pending state survives.
// CONFIGURATION
//  MIPS32_FWD_EN defined: datapath has EX/MEM->EX forwarding.
//    Non-load producers write no counter, so ALU->use gives 0 bubbles.
//    Loads set cnt[id_rd] <= LU_DIST-1, so load->use gives 1 bubble by default.
//  MIPS32_FWD_EN undefined: every register writer, including loads, uses WB_DIST; LU_DIST unused.
// TESTING
//  1 ADDI R10,R0,200 issued at t, then LW R3,0(R10): id_ready=0 and bubble=1 at t+1,t+2.
//    LW issues at t+3; stall_cnt=2.
//  2 MUL R2,R2,R3 then ADDI R5,R0,1: back-to-back issue, bubble=0, stall_cnt unchanged.
//  3 Producer with rd=0, then consumer reading R0: no stall.
//  4 HLT issued at t: DRAIN at t+1,t+2; pipe_halted=1 from t+3.
//    Repeat with branch_taken=1 at t+1: returns to RUN, pipe_halted stays 0.
//  5 rst pulsed during stall of case 1: after release, LW issues in first cycle; busy=0, stall_cnt=0.
//  6 MIPS32_FWD_EN: LW R3 then MUL R2,R2,R3 gives 1 bubble.
//    SUBI R3,R3,1 then BNEQZ R3 gives 0 bubbles.

Source files
------------

// File: rtl/mips32_issue_interlock.sv
// mips32_issue_interlock
// Scoreboard issue controller at the ID stage of the 5-stage MIPS32 pipeline.
// Holds a decoded instruction in ID while any source register is still in
// flight, squashes wrong-path issue on a taken branch and drains HLT to a halt.
// Optional feature: define MIPS32_FWD_EN when the datapath has EX/MEM->EX
// forwarding; only loads are then tracked, with the shorter LU_DIST distance.
module mips32_issue_interlock #(
  parameter int WB_DIST = 3,
  parameter int LU_DIST = 2,
  parameter int CNT_W   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_wr_en,
  input  logic [4:0]  id_rd,
  input  logic        id_is_load,
  input  logic        id_is_halt,
  input  logic        branch_taken,
  output logic        id_ready,
  output logic        bubble,
  output logic        pipe_halted,
  output logic        busy,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] WB_SET  = CNT_W'(WB_DIST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef MIPS32_FWD_EN
  localparam logic [CNT_W-1:0] LD_SET    = CNT_W'(LU_DIST - 1);
  localparam bit               TRACK_ALU = 1'b0;
`else
  localparam logic [CNT_W-1:0] LD_SET    = WB_SET;
  localparam bit               TRACK_ALU = 1'b1;
`endif

  // Both distances must fit in the scoreboard counters.
  if ((WB_DIST < 1) || (LU_DIST < 1) || (WB_DIST - 1 > CNT_MAX) || (LU_DIST - 1 > CNT_MAX)) begin : g_param_check
    $error("mips32_issue_interlock: WB_DIST/LU_DIST out of range for CNT_W");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt [32];
  logic [CNT_W-1:0] drain_tmr;
  logic             hazard;
  logic             issue;
  logic             sb_write;
  logic [CNT_W-1:0] sb_val;
  logic             any_pending;

  // Hazard detection, issue decision and scoreboard write request.
  always_comb begin
    hazard   = (id_uses_rs && (id_rs != 5'd0) && (cnt[id_rs] != '0)) ||
               (id_uses_rt && (id_rt != 5'd0) && (cnt[id_rt] != '0));
    id_ready = (state == RUN) && !hazard && !branch_taken;
    issue    = id_valid && id_ready;
    bubble   = !issue;
    sb_write = issue && id_wr_en && (id_rd != 5'd0) && (TRACK_ALU || id_is_load);
    sb_val   = id_is_load ? LD_SET : WB_SET;
  end

  // Busy whenever a register write is still in flight or a halt is draining.
  always_comb begin
    any_pending = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (cnt[i] != '0) any_pending = 1'b1;
    end
    busy = any_pending || (state == DRAIN);
  end

  // Scoreboard: count down every in-flight entry; a new producer reloads its entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < 32; i++) begin
        if (sb_write && (id_rd == 5'(i))) cnt[i] <= sb_val;
        else if (cnt[i] != '0)            cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end

  // Halt sequencing: RUN -> DRAIN on HLT issue, DRAIN -> HALTED once in-flight writes retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      drain_tmr   <= '0;
      pipe_halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (issue && id_is_halt) begin
            if (WB_SET == '0) begin
              state       <= HALTED;
              pipe_halted <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_tmr <= WB_SET;
            end
          end
        end
        DRAIN: begin
          drain_tmr <= drain_tmr - CNT_ONE;
          if (branch_taken) begin
            state <= RUN;
          end else if (drain_tmr <= CNT_ONE) begin
            state       <= HALTED;
            pipe_halted <= 1'b1;
          end
        end
        HALTED: begin
          state       <= HALTED;
          pipe_halted <= 1'b1;
        end
        default: begin
          state       <= RUN;
          pipe_halted <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles lost to genuine RAW hazards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (id_valid && hazard && (state == RUN) && !branch_taken && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
